// File: rtl/ex_stage_pkg.sv
// Shared execute-stage codes: ALU sub-ops, result classes, reset/write-enable levels.
// Imported by the ID/EX register, the execute stage and its interface.
package ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 8;
    localparam int SEL_W  = 3;
    localparam int SH_W   = 5;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic [ADDR_W-1:0] NOP_REG_ADDR = 5'b00000;

    localparam logic [OP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [OP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [OP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [OP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [OP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [OP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [OP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [OP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [OP_W-1:0] EXE_MOVZ_OP = 8'b0000_1010;
    localparam logic [OP_W-1:0] EXE_MOVN_OP = 8'b0000_1011;
    localparam logic [OP_W-1:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [OP_W-1:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [OP_W-1:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [OP_W-1:0] EXE_MTLO_OP = 8'b0001_0011;

    localparam logic [SEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [SEL_W-1:0] EXE_RES_MOVE  = 3'b011;

endpackage

// File: rtl/ex_stage_if.sv
// Decoded-instruction bus from ID into EX and the EX result bus towards MEM/ID.
// slave = execute stage, master = decode/downstream side.
interface ex_stage_if
    import ex_stage_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int OP_W_P   = OP_W,
    parameter int SEL_W_P  = SEL_W
);
    logic [OP_W_P-1:0]   i_alu_op;
    logic [SEL_W_P-1:0]  i_alu_sel;
    logic [DATA_W_P-1:0] i_op_reg_0;
    logic [DATA_W_P-1:0] i_op_reg_1;
    logic                i_reg_wen;
    logic [ADDR_W_P-1:0] i_reg_waddr;

    logic                o_wen;
    logic [ADDR_W_P-1:0] o_waddr;
    logic [DATA_W_P-1:0] o_wdata;
    logic                o_whilo;
    logic [DATA_W_P-1:0] o_hi;
    logic [DATA_W_P-1:0] o_lo;

    modport slave (
        input  i_alu_op, i_alu_sel, i_op_reg_0, i_op_reg_1, i_reg_wen, i_reg_waddr,
        output o_wen, o_waddr, o_wdata, o_whilo, o_hi, o_lo
    );

    modport master (
        output i_alu_op, i_alu_sel, i_op_reg_0, i_op_reg_1, i_reg_wen, i_reg_waddr,
        input  o_wen, o_waddr, o_wdata, o_whilo, o_hi, o_lo
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: reset > flush > stall_ex (hold) > stall_id (bubble) > load.
// A bubble is a NOP with no register write.
module id_ex_reg
    import ex_stage_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int OP_W_P   = OP_W,
    parameter int SEL_W_P  = SEL_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_stall_ex,
    input  logic                i_stall_id,
    input  logic                i_flush,
    input  logic [OP_W_P-1:0]   i_alu_op,
    input  logic [SEL_W_P-1:0]  i_alu_sel,
    input  logic [DATA_W_P-1:0] i_op_reg_0,
    input  logic [DATA_W_P-1:0] i_op_reg_1,
    input  logic                i_reg_wen,
    input  logic [ADDR_W_P-1:0] i_reg_waddr,
    output logic [OP_W_P-1:0]   ex_alu_op,
    output logic [SEL_W_P-1:0]  ex_alu_sel,
    output logic [DATA_W_P-1:0] ex_op_0,
    output logic [DATA_W_P-1:0] ex_op_1,
    output logic                ex_wen,
    output logic [ADDR_W_P-1:0] ex_waddr
);

    always_ff @(posedge i_clk) begin
        if ((i_rst_n == RST_ENABLE) || i_flush || (!i_stall_ex && i_stall_id)) begin
            ex_alu_op  <= EXE_NOP_OP;
            ex_alu_sel <= EXE_RES_NOP;
            ex_op_0    <= '0;
            ex_op_1    <= '0;
            ex_wen     <= WRITE_DISABLE;
            ex_waddr   <= NOP_REG_ADDR;
        end else if (!i_stall_ex) begin
            ex_alu_op  <= i_alu_op;
            ex_alu_sel <= i_alu_sel;
            ex_op_0    <= i_op_reg_0;
            ex_op_1    <= i_op_reg_1;
            ex_wen     <= i_reg_wen;
            ex_waddr   <= i_reg_waddr;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registers decoded op, then computes logic/shift/move results combinationally.
// Latency 1 cycle from ID; HI/LO forwarded from MEM, then WB, then architectural copy.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int OP_W_P   = OP_W,
    parameter int SEL_W_P  = SEL_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_stall_ex,
    input  logic                i_stall_id,
    input  logic                i_flush,
    input  logic [DATA_W_P-1:0] i_hi,
    input  logic [DATA_W_P-1:0] i_lo,
    input  logic                i_mem_whilo,
    input  logic [DATA_W_P-1:0] i_mem_hi,
    input  logic [DATA_W_P-1:0] i_mem_lo,
    input  logic                i_wb_whilo,
    input  logic [DATA_W_P-1:0] i_wb_hi,
    input  logic [DATA_W_P-1:0] i_wb_lo,
    ex_stage_if.slave           bus
);

    logic [OP_W_P-1:0]   ex_alu_op;
    logic [SEL_W_P-1:0]  ex_alu_sel;
    logic [DATA_W_P-1:0] ex_op_0;
    logic [DATA_W_P-1:0] ex_op_1;
    logic                ex_wen;
    logic [ADDR_W_P-1:0] ex_waddr;

    id_ex_reg #(
        .DATA_W_P (DATA_W_P),
        .ADDR_W_P (ADDR_W_P),
        .OP_W_P   (OP_W_P),
        .SEL_W_P  (SEL_W_P)
    ) u_id_ex_reg (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_stall_ex  (i_stall_ex),
        .i_stall_id  (i_stall_id),
        .i_flush     (i_flush),
        .i_alu_op    (bus.i_alu_op),
        .i_alu_sel   (bus.i_alu_sel),
        .i_op_reg_0  (bus.i_op_reg_0),
        .i_op_reg_1  (bus.i_op_reg_1),
        .i_reg_wen   (bus.i_reg_wen),
        .i_reg_waddr (bus.i_reg_waddr),
        .ex_alu_op   (ex_alu_op),
        .ex_alu_sel  (ex_alu_sel),
        .ex_op_0     (ex_op_0),
        .ex_op_1     (ex_op_1),
        .ex_wen      (ex_wen),
        .ex_waddr    (ex_waddr)
    );

    logic [DATA_W_P-1:0] hi_fwd;
    logic [DATA_W_P-1:0] lo_fwd;
    logic [SH_W-1:0]     sh_amt;

    always_comb begin
        hi_fwd = i_hi;
        lo_fwd = i_lo;
        if (i_mem_whilo) begin
            hi_fwd = i_mem_hi;
            lo_fwd = i_mem_lo;
        end else if (i_wb_whilo) begin
            hi_fwd = i_wb_hi;
            lo_fwd = i_wb_lo;
        end
    end

    assign sh_amt = ex_op_0[SH_W-1:0];

    logic                wen;
    logic [DATA_W_P-1:0] wdata;
    logic                whilo;
    logic [DATA_W_P-1:0] hi;
    logic [DATA_W_P-1:0] lo;

    always_comb begin
        wen   = ex_wen;
        wdata = '0;
        whilo = 1'b0;
        hi    = '0;
        lo    = '0;
        case (ex_alu_sel)
            EXE_RES_LOGIC: begin
                case (ex_alu_op)
                    EXE_OR_OP:  wdata = ex_op_0 | ex_op_1;
                    EXE_AND_OP: wdata = ex_op_0 & ex_op_1;
                    EXE_XOR_OP: wdata = ex_op_0 ^ ex_op_1;
                    EXE_NOR_OP: wdata = ~(ex_op_0 | ex_op_1);
                    default:    wdata = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (ex_alu_op)
                    EXE_SLL_OP: wdata = ex_op_1 << sh_amt;
                    EXE_SRL_OP: wdata = ex_op_1 >> sh_amt;
                    EXE_SRA_OP: wdata = $signed(ex_op_1) >>> sh_amt;
                    default:    wdata = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (ex_alu_op)
                    EXE_MFHI_OP: wdata = hi_fwd;
                    EXE_MFLO_OP: wdata = lo_fwd;
                    EXE_MOVN_OP,
                    EXE_MOVZ_OP: wdata = ex_op_0;
                    // HI/LO moves write the pair; the half not targeted keeps its forwarded value
                    EXE_MTHI_OP: begin
                        wen   = WRITE_DISABLE;
                        whilo = 1'b1;
                        hi    = ex_op_0;
                        lo    = lo_fwd;
                    end
                    EXE_MTLO_OP: begin
                        wen   = WRITE_DISABLE;
                        whilo = 1'b1;
                        hi    = hi_fwd;
                        lo    = ex_op_0;
                    end
                    default: wdata = '0;
                endcase
            end
            default: wdata = '0;
        endcase
    end

    assign bus.o_wen   = wen;
    assign bus.o_waddr = ex_waddr;
    assign bus.o_wdata = wdata;
    assign bus.o_whilo = whilo;
    assign bus.o_hi    = hi;
    assign bus.o_lo    = lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, logic/shift/move results, HI/LO forwarding, stall/flush/bubble.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall_ex;
    logic        i_stall_id;
    logic        i_flush;
    logic [31:0] i_hi, i_lo;
    logic        i_mem_whilo;
    logic [31:0] i_mem_hi, i_mem_lo;
    logic        i_wb_whilo;
    logic [31:0] i_wb_hi, i_wb_lo;

    int vectors = 0;
    int errs    = 0;

    ex_stage_if bus ();

    ex_stage dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_stall_ex  (i_stall_ex),
        .i_stall_id  (i_stall_id),
        .i_flush     (i_flush),
        .i_hi        (i_hi),
        .i_lo        (i_lo),
        .i_mem_whilo (i_mem_whilo),
        .i_mem_hi    (i_mem_hi),
        .i_mem_lo    (i_mem_lo),
        .i_wb_whilo  (i_wb_whilo),
        .i_wb_hi     (i_wb_hi),
        .i_wb_lo     (i_wb_lo),
        .bus         (bus.slave)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic wen, input logic [4:0] waddr);
        bus.i_alu_op    = op;
        bus.i_alu_sel   = sel;
        bus.i_op_reg_0  = a;
        bus.i_op_reg_1  = b;
        bus.i_reg_wen   = wen;
        bus.i_reg_waddr = waddr;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        step();
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo, bus.o_hi, bus.o_lo} !== 103'd0) begin
            $display("FAIL reset_outputs: got wen=%b waddr=%h wdata=%h whilo=%b hi=%h lo=%h want all 0",
                     bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo, bus.o_hi, bus.o_lo);
            errs++;
        end
        i_rst_n = 1'b1;
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo, bus.o_hi, bus.o_lo} !== 103'd0) begin
            $display("FAIL idle_outputs: got wen=%b waddr=%h wdata=%h whilo=%b want all 0",
                     bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo);
            errs++;
        end
    endtask

    task automatic test_logic();
        set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_1100, 32'h0000_0011, 1'b1, 5'd3);
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata} !== {1'b1, 5'd3, 32'h0000_1111}) begin
            $display("FAIL ori: got wen=%b waddr=%0d wdata=%h want wen=1 waddr=3 wdata=00001111",
                     bus.o_wen, bus.o_waddr, bus.o_wdata);
            errs++;
        end
        set_op(EXE_XOR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h0000_0FF0, 1'b1, 5'd9);
        step();
        vectors++;
        if ({bus.o_waddr, bus.o_wdata} !== {5'd9, 32'h0000_F0F0}) begin
            $display("FAIL xor: got waddr=%0d wdata=%h want waddr=9 wdata=0000f0f0", bus.o_waddr, bus.o_wdata);
            errs++;
        end
        set_op(EXE_NOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0000_FF00, 1'b1, 5'd9);
        step();
        vectors++;
        if (bus.o_wdata !== 32'h0000_00FF) begin
            $display("FAIL nor: got %h want 000000ff", bus.o_wdata);
            errs++;
        end
    endtask

    task automatic test_shift();
        set_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd5);
        step();
        vectors++;
        if (bus.o_wdata !== 32'hF800_0000) begin
            $display("FAIL sra: got %h want f8000000", bus.o_wdata);
            errs++;
        end
        set_op(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd5);
        step();
        vectors++;
        if (bus.o_wdata !== 32'h0800_0000) begin
            $display("FAIL srl: got %h want 08000000", bus.o_wdata);
            errs++;
        end
        set_op(EXE_SLL_OP, EXE_RES_SHIFT, 32'd31, 32'd1, 1'b1, 5'd5);
        step();
        vectors++;
        if (bus.o_wdata !== 32'h8000_0000) begin
            $display("FAIL sll: got %h want 80000000", bus.o_wdata);
            errs++;
        end
        set_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd0, 32'h8000_0001, 1'b1, 5'd5);
        step();
        vectors++;
        if (bus.o_wdata !== 32'h8000_0001) begin
            $display("FAIL sra_zero: got %h want 80000001", bus.o_wdata);
            errs++;
        end
    endtask

    task automatic test_hilo_fwd();
        i_hi = 32'h1; i_wb_hi = 32'h2; i_mem_hi = 32'h3;
        i_lo = 32'h11; i_wb_lo = 32'h22; i_mem_lo = 32'h33;
        i_wb_whilo = 1'b1; i_mem_whilo = 1'b1;
        set_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 1'b1, 5'd8);
        step();
        vectors++;
        if (bus.o_wdata !== 32'h3) begin
            $display("FAIL mfhi_mem: got %h want 00000003", bus.o_wdata);
            errs++;
        end
        i_mem_whilo = 1'b0;
        #1;
        vectors++;
        if (bus.o_wdata !== 32'h2) begin
            $display("FAIL mfhi_wb: got %h want 00000002", bus.o_wdata);
            errs++;
        end
        i_wb_whilo = 1'b0;
        #1;
        vectors++;
        if (bus.o_wdata !== 32'h1) begin
            $display("FAIL mfhi_arch: got %h want 00000001", bus.o_wdata);
            errs++;
        end
        i_wb_whilo = 1'b1;
        set_op(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 1'b1, 5'd8);
        step();
        vectors++;
        if (bus.o_wdata !== 32'h22) begin
            $display("FAIL mflo_wb: got %h want 00000022", bus.o_wdata);
            errs++;
        end
        i_wb_whilo = 1'b0;
    endtask

    task automatic test_mtlo();
        i_hi = 32'h55; i_lo = 32'h66;
        set_op(EXE_MTLO_OP, EXE_RES_MOVE, 32'h0000_ABCD, 32'h0, 1'b0, 5'd0);
        step();
        vectors++;
        if ({bus.o_whilo, bus.o_lo, bus.o_hi, bus.o_wen} !== {1'b1, 32'h0000_ABCD, 32'h55, 1'b0}) begin
            $display("FAIL mtlo: got whilo=%b lo=%h hi=%h wen=%b want whilo=1 lo=0000abcd hi=00000055 wen=0",
                     bus.o_whilo, bus.o_lo, bus.o_hi, bus.o_wen);
            errs++;
        end
        set_op(EXE_MTHI_OP, EXE_RES_MOVE, 32'h1234_5678, 32'h0, 1'b0, 5'd0);
        step();
        vectors++;
        if ({bus.o_whilo, bus.o_hi, bus.o_lo} !== {1'b1, 32'h1234_5678, 32'h66}) begin
            $display("FAIL mthi: got whilo=%b hi=%h lo=%h want whilo=1 hi=12345678 lo=00000066",
                     bus.o_whilo, bus.o_hi, bus.o_lo);
            errs++;
        end
        set_op(EXE_MOVN_OP, EXE_RES_MOVE, 32'hCAFE_0001, 32'h5, 1'b1, 5'd12);
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo} !== {1'b1, 5'd12, 32'hCAFE_0001, 1'b0}) begin
            $display("FAIL movn: got wen=%b waddr=%0d wdata=%h whilo=%b want wen=1 waddr=12 wdata=cafe0001 whilo=0",
                     bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo);
            errs++;
        end
        set_op(8'hEE, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd13);
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo} !== {1'b1, 5'd13, 32'h0, 1'b0}) begin
            $display("FAIL unknown_op: got wen=%b waddr=%0d wdata=%h whilo=%b want wen=1 waddr=13 wdata=0 whilo=0",
                     bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo);
            errs++;
        end
    endtask

    task automatic test_stall();
        set_op(EXE_AND_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 5'd7);
        step();
        vectors++;
        if (bus.o_wdata !== 32'h0000_F000) begin
            $display("FAIL and: got %h want 0000f000", bus.o_wdata);
            errs++;
        end
        i_stall_ex = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h1 << k, 32'hFFFF_0000, 1'b1, 5'(20 + k));
            step();
            vectors++;
            if ({bus.o_wen, bus.o_waddr, bus.o_wdata} !== {1'b1, 5'd7, 32'h0000_F000}) begin
                $display("FAIL stall_hold_%0d: got wen=%b waddr=%0d wdata=%h want wen=1 waddr=7 wdata=0000f000",
                         k, bus.o_wen, bus.o_waddr, bus.o_wdata);
                errs++;
            end
        end
        i_stall_ex = 1'b0;
        i_stall_id = 1'b1;
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata} !== {1'b0, 5'd0, 32'h0}) begin
            $display("FAIL stall_id_bubble: got wen=%b waddr=%0d wdata=%h want all 0",
                     bus.o_wen, bus.o_waddr, bus.o_wdata);
            errs++;
        end
        i_stall_id = 1'b0;
    endtask

    task automatic test_flush();
        set_op(EXE_MTHI_OP, EXE_RES_MOVE, 32'h9, 32'h0, 1'b0, 5'd0);
        step();
        i_flush = 1'b1;
        i_stall_ex = 1'b1;
        set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2, 1'b1, 5'd4);
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo} !== {1'b0, 5'd0, 32'h0, 1'b0}) begin
            $display("FAIL flush_over_stall: got wen=%b waddr=%0d wdata=%h whilo=%b want all 0",
                     bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo);
            errs++;
        end
        i_flush = 1'b0;
        i_stall_ex = 1'b0;
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata} !== {1'b1, 5'd4, 32'h3}) begin
            $display("FAIL load_after_flush: got wen=%b waddr=%0d wdata=%h want wen=1 waddr=4 wdata=00000003",
                     bus.o_wen, bus.o_waddr, bus.o_wdata);
            errs++;
        end
        i_rst_n = 1'b0;
        i_stall_ex = 1'b1;
        step();
        vectors++;
        if ({bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo} !== {1'b0, 5'd0, 32'h0, 1'b0}) begin
            $display("FAIL reset_mid_stall: got wen=%b waddr=%0d wdata=%h whilo=%b want all 0",
                     bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_whilo);
            errs++;
        end
        i_rst_n = 1'b1;
        i_stall_ex = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_stall_ex = 1'b0; i_stall_id = 1'b0; i_flush = 1'b0;
        i_hi = '0; i_lo = '0;
        i_mem_whilo = 1'b0; i_mem_hi = '0; i_mem_lo = '0;
        i_wb_whilo = 1'b0; i_wb_hi = '0; i_wb_lo = '0;
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
        test_reset();
        test_logic();
        test_shift();
        test_hilo_fwd();
        test_mtlo();
        test_stall();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
